perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_EVT, default 4, meaning number of event counter channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of every counter (8..64).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port run  input  1  counting enable (CPU not stalled/halted externally).
REQ-006 SHALL have port evt  input  NUM_EVT  per-channel event strobe, one count per cycle.
REQ-007 SHALL have port clr  input  1  synchronous clear of counters, overflow flags, halt latch.
REQ-008 SHALL have ports syscall_t  input  1 (syscall retiring), a_val  input  32 (syscall code register), b_val  input  32 (syscall argument).
REQ-009 SHALL have ports halt  output  1 (sticky halt latch) and disp_val  output  32, disp_vld  output  1 (display latch, one-cycle update pulse).
REQ-010 SHALL have ports rd_req  input  1, rd_idx  input  5, rd_vld  output  1, rd_rdy  input  1, rd_data  output  CNT_W, rd_err  output  1 (readout handshake).
REQ-011 SHALL have port ovf  output  NUM_EVT+1  sticky overflow flags, bit 0 = cycle counter, bit i+1 = evt[i].

Function
REQ-012 Cycle counter SHALL increment by 1 in each cycle with run=1, halt=0, clr=0.
REQ-013 Event counter i SHALL increment by 1 in each cycle with evt[i]=1, run=1, halt=0, clr=0.
REQ-014 halt SHALL set on the clock edge after syscall_t=1 with a_val==10, and hold until clr or rst; that syscall cycle itself still counts.
REQ-015 Display: syscall_t=1, a_val==34, halt=0 SHALL load disp_val<=b_val and pulse disp_vld high for exactly one cycle; disp_val otherwise holds.
REQ-016 Counter at all-ones that increments SHALL wrap to 0 and set its ovf bit (wrap mode, see REQ-027).
REQ-017 clr SHALL take priority over any simultaneous increment, halt set, or overflow; disp_val/disp_vld unaffected by clr.
REQ-018 Readout FSM SHALL have states IDLE, RESP; rd_req is accepted only in IDLE.
REQ-019 IDLE with rd_req=1: SHALL capture the selected counter value (pre-increment value of that cycle) into rd_data, go to RESP, assert rd_vld next cycle.
REQ-020 rd_idx 0 selects cycle counter, 1..NUM_EVT select evt[rd_idx-1]; larger index SHALL return rd_data=0 with rd_err=1.
REQ-021 RESP SHALL hold rd_vld, rd_data, rd_err stable until rd_rdy=1, then return to IDLE; rd_req in RESP is ignored (not queued).
REQ-022 Readout SHALL operate regardless of halt, run and clr; a clr during RESP does not alter captured rd_data.

Reset
REQ-023 rst SHALL asynchronously force all counters, ovf, halt, disp_val, disp_vld, rd_vld, rd_err, rd_data to 0 and FSM to IDLE.
REQ-024 rst asserted during RESP SHALL abort the transaction; no rd_vld after release.
REQ-025 First count SHALL occur on the first rising edge after rst deasserts with enables valid.

Configuration
REQ-026 Macro PERF_SATURATE_EN SHALL select counter overflow behaviour.
REQ-027 Without PERF_SATURATE_EN: counters wrap per REQ-016.
REQ-028 With PERF_SATURATE_EN: counter at all-ones SHALL hold all-ones on increment and set its ovf bit; all other behaviour identical.

Structure
REQ-029 Package perf_pkg SHALL hold: readout state enum (IDLE, RESP), syscall code constants SYS_EXIT=10 and SYS_SHOW=34, index width constant 5.
REQ-030 One sub-module perf_cnt (CNT_W, inc, clr, value, ovf) SHALL be instantiated NUM_EVT+1 times; mode selection lives inside it.

Verification
REQ-031 Reset, run=1, evt=4'b0101 for 10 cycles, then rd_idx=1 read -> rd_data=10 (evt[0]); rd_idx=0 read -> cycle count ≥10, exact per capture cycle.
REQ-032 syscall_t with a_val=34, b_val=0xDEADBEEF -> disp_val=0xDEADBEEF, disp_vld high one cycle; then a_val=10 -> halt=1 next edge, counters frozen 20 cycles, clr -> halt=0, counters 0.
REQ-033 CNT_W=8, evt[0] held 256 cycles -> wrap build: count 0, ovf[1]=1; PERF_SATURATE_EN build: count 255, ovf[1]=1.
REQ-034 rd_req rd_idx=9 with NUM_EVT=4 -> rd_vld, rd_data=0, rd_err=1; rd_rdy held low 5 cycles -> outputs stable, second rd_req ignored.
REQ-035 clr and evt[2] same cycle -> counter 0; rst pulse mid-RESP -> rd_vld=0 immediately, FSM IDLE, all outputs 0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

  // Readout handshake states.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

  // Syscall codes recognised on a_val when syscall_t retires.
  localparam logic [31:0] SYS_EXIT = 32'd10;
  localparam logic [31:0] SYS_SHOW = 32'd34;

  // Width of the readout counter index.
  localparam int IDX_W = 5;

endpackage

// File: rtl/perf_cnt.sv
// Single performance counter with sticky overflow flag.
// Overflow behaviour: wraps to zero by default; define PERF_SATURATE_EN
// to make the counter stick at all-ones instead. Either way the ovf flag
// sets on the first increment attempted at all-ones.
module perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  // Counter and overflow flag; clr wins over any increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&value) begin
        ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
        value <= value;
`else
        value <= '0;
`endif
      end else begin
        value <= value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Performance counter bank: one cycle counter plus NUM_EVT event counters,
// a syscall-driven halt latch and display register, and a single-entry
// readout handshake. Overflow mode is chosen by PERF_SATURATE_EN (see perf_cnt).
//
// Readout FSM
//   state | meaning
//   IDLE  | waiting for rd_req; captures selected counter on accept
//   RESP  | rd_vld high, rd_data/rd_err held until rd_rdy
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               clr,
  input  logic               syscall_t,
  input  logic [31:0]        a_val,
  input  logic [31:0]        b_val,
  output logic               halt,
  output logic [31:0]        disp_val,
  output logic               disp_vld,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_vld,
  input  logic               rd_rdy,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_err,
  output logic [NUM_EVT:0]   ovf
);

  logic [CNT_W-1:0] cnt_val [NUM_EVT+1];
  logic [NUM_EVT:0] cnt_inc;
  logic             count_en;
  logic             show;
  logic             idx_ok;
  logic [CNT_W-1:0] sel_val;
  rd_state_t        state;
  rd_state_t        state_nxt;

  assign count_en = run & ~halt;
  assign show     = syscall_t & (a_val == SYS_SHOW) & ~halt;
  assign idx_ok   = (rd_idx <= IDX_W'(NUM_EVT));

  // Increment enables: slot 0 is the cycle counter, slot i+1 follows evt[i].
  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = count_en;
    for (int i = 0; i < NUM_EVT; i++) begin
      cnt_inc[i+1] = count_en & evt[i];
    end
  end

  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
    perf_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[g]),
      .clr   (clr),
      .value (cnt_val[g]),
      .ovf   (ovf[g])
    );
  end

  // Sticky halt latch set by the exit syscall, released only by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt <= 1'b0;
    end else if (clr) begin
      halt <= 1'b0;
    end else if (syscall_t && (a_val == SYS_EXIT)) begin
      halt <= 1'b1;
    end
  end

  // Display latch with single-cycle update pulse; deliberately ignores clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_val <= '0;
      disp_vld <= 1'b0;
    end else begin
      disp_vld <= show;
      if (show) begin
        disp_val <= b_val;
      end
    end
  end

  // Counter select mux for readout; out-of-range indices resolve to zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        sel_val = cnt_val[i];
      end
    end
  end

  // Readout state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Readout next-state and rd_vld decode.
  always_comb begin
    state_nxt = state;
    rd_vld    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rd_vld = 1'b1;
        if (rd_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the pre-increment counter value when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else if ((state == IDLE) && rd_req) begin
      rd_data <= idx_ok ? sel_val : '0;
      rd_err  <= ~idx_ok;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (NUM_EVT=4, CNT_W=8).
// Expected overflow results follow PERF_SATURATE_EN when it is defined.
module tb_perf_counter_bank;

  localparam int NUM_EVT = 4;
  localparam int CNT_W   = 8;

`ifdef PERF_SATURATE_EN
  localparam logic [CNT_W-1:0] OVF_CNT   = 8'hFF;
  localparam logic [CNT_W-1:0] AFTER3    = 8'hFF;
`else
  localparam logic [CNT_W-1:0] OVF_CNT   = 8'h00;
  localparam logic [CNT_W-1:0] AFTER3    = 8'h03;
`endif

  logic               clk;
  logic               rst;
  logic               run;
  logic [NUM_EVT-1:0] evt;
  logic               clr;
  logic               syscall_t;
  logic [31:0]        a_val;
  logic [31:0]        b_val;
  logic               halt;
  logic [31:0]        disp_val;
  logic               disp_vld;
  logic               rd_req;
  logic [4:0]         rd_idx;
  logic               rd_vld;
  logic               rd_rdy;
  logic [CNT_W-1:0]   rd_data;
  logic               rd_err;
  logic [NUM_EVT:0]   ovf;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] rdat;
  logic             rerr;

  perf_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .evt       (evt),
    .clr       (clr),
    .syscall_t (syscall_t),
    .a_val     (a_val),
    .b_val     (b_val),
    .halt      (halt),
    .disp_val  (disp_val),
    .disp_vld  (disp_vld),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_vld    (rd_vld),
    .rd_rdy    (rd_rdy),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Full handshake: request, bounded wait for rd_vld, accept with rd_rdy.
  task automatic do_read(input logic [4:0] idx, output logic [CNT_W-1:0] data, output logic err);
    int n;
    rd_idx = idx;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    n = 0;
    while (!rd_vld && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rd_vld_seen", rd_vld, 1);
    data = rd_data;
    err  = rd_err;
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    chk("rd_vld_drop", rd_vld, 0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; evt = '0; clr = 1'b0;
    syscall_t = 1'b0; a_val = '0; b_val = '0;
    rd_req = 1'b0; rd_idx = '0; rd_rdy = 1'b0;
    cycles(2);

    // reset state
    chk("rst_ovf", ovf, 0);
    chk("rst_halt", halt, 0);
    chk("rst_disp_val", disp_val, 0);
    chk("rst_disp_vld", disp_vld, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);

    // 10 counting cycles, evt = 0101
    rst = 1'b0; run = 1'b1; evt = 4'b0101;
    cycles(10);
    run = 1'b0; evt = '0;
    do_read(5'd1, rdat, rerr); chk("evt0_10", rdat, 10); chk("evt0_err", rerr, 0);
    do_read(5'd3, rdat, rerr); chk("evt2_10", rdat, 10);
    do_read(5'd2, rdat, rerr); chk("evt1_0", rdat, 0);
    // capture is pre-increment: 10 captured, counter runs two cycles during the read
    run = 1'b1;
    do_read(5'd0, rdat, rerr); chk("cyc_capture", rdat, 10);
    run = 1'b0;
    do_read(5'd0, rdat, rerr); chk("cyc_12", rdat, 12);

    // bad index, rd_rdy held low, second request must be ignored
    rd_idx = 5'd9; rd_req = 1'b1;
    @(negedge clk);
    chk("err_vld", rd_vld, 1);
    chk("err_data", rd_data, 0);
    chk("err_flag", rd_err, 1);
    rd_idx = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("err_hold", {rd_vld, rd_err, rd_data}, {1'b1, 1'b1, 8'h00});
    end
    rd_req = 1'b0; rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    chk("err_done", rd_vld, 0);
    @(negedge clk);
    chk("no_queue", rd_vld, 0);

    // display syscall
    syscall_t = 1'b1; a_val = 32'd34; b_val = 32'hDEADBEEF;
    @(negedge clk);
    syscall_t = 1'b0;
    chk("disp_val", disp_val, 32'hDEADBEEF);
    chk("disp_pulse", disp_vld, 1);
    @(negedge clk);
    chk("disp_pulse_end", disp_vld, 0);
    chk("disp_hold", disp_val, 32'hDEADBEEF);

    // exit syscall: its own cycle still counts, then everything freezes
    run = 1'b1; evt = 4'b1111;
    syscall_t = 1'b1; a_val = 32'd10;
    @(negedge clk);
    syscall_t = 1'b0;
    chk("halt_set", halt, 1);
    cycles(20);
    syscall_t = 1'b1; a_val = 32'd34; b_val = 32'h12345678;
    @(negedge clk);
    syscall_t = 1'b0;
    chk("disp_blocked_vld", disp_vld, 0);
    chk("disp_blocked_val", disp_val, 32'hDEADBEEF);
    chk("halt_hold", halt, 1);
    do_read(5'd0, rdat, rerr); chk("halt_cyc", rdat, 13);
    do_read(5'd1, rdat, rerr); chk("halt_evt0", rdat, 11);
    do_read(5'd2, rdat, rerr); chk("halt_evt1", rdat, 1);

    // clr releases halt and zeroes counters, leaves display alone
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; run = 1'b0; evt = '0;
    chk("clr_halt", halt, 0);
    chk("clr_disp", disp_val, 32'hDEADBEEF);
    do_read(5'd0, rdat, rerr); chk("clr_cyc", rdat, 0);
    do_read(5'd4, rdat, rerr); chk("clr_evt3", rdat, 0);

    // clr beats a simultaneous evt[2] increment
    run = 1'b1; evt = 4'b0100;
    cycles(3);
    run = 1'b0; evt = '0;
    do_read(5'd3, rdat, rerr); chk("evt2_3", rdat, 3);
    run = 1'b1; evt = 4'b0100; clr = 1'b1;
    @(negedge clk);
    run = 1'b0; evt = '0; clr = 1'b0;
    do_read(5'd3, rdat, rerr); chk("clr_prio", rdat, 0);
    chk("clr_prio_ovf", ovf, 0);

    // overflow boundary on evt[0] and cycle counter
    run = 1'b1; evt = 4'b0001;
    cycles(255);
    chk("pre_ovf", ovf, 0);
    cycles(1);
    run = 1'b0; evt = '0;
    chk("ovf_bits", ovf, 5'b00011);
    do_read(5'd1, rdat, rerr); chk("ovf_evt0", rdat, OVF_CNT);
    do_read(5'd0, rdat, rerr); chk("ovf_cyc", rdat, OVF_CNT);

    // reset in the middle of RESP
    run = 1'b1;
    cycles(3);
    run = 1'b0;
    rd_idx = 5'd0; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("resp_vld", rd_vld, 1);
    chk("resp_data", rd_data, AFTER3);
    #2 rst = 1'b1;
    #1;
    chk("abort_vld", rd_vld, 0);
    chk("abort_data", rd_data, 0);
    chk("abort_err", rd_err, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_disp", {disp_vld, disp_val}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    chk("post_rst_vld", rd_vld, 0);
    do_read(5'd0, rdat, rerr); chk("post_rst_cyc", rdat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
